// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared constants and types for the matrix-vector dot-product engine.
//   DW               element / result width (two's-complement signed)
//   N                row length and number of rows per job (N >= 2)
//   AW               accumulator width: 2*DW product bits plus $clog2(N)
//                    growth bits, so the sum of N products never overflows
//   mxv_dot_state_t  engine FSM states (IDLE, ACCUM, OUTPUT)
// -----------------------------------------------------------------------------
package mxv_pkg;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AW = 2 * DW + $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mxv_dot_state_t;

endpackage

// File: rtl/mxv_mac.sv
// -----------------------------------------------------------------------------
// mxv_mac
// Signed multiply-accumulate with DW-bit result reduction.
//
// Configuration macro: MXV_SATURATE_EN
//   defined     -> o_result is the accumulator clamped to the DW-bit signed range
//   not defined -> o_result is the low DW bits of the accumulator (wrap-around)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low (accumulator -> 0)
//   i_clr     in   synchronous clear of the accumulator (wins over i_en)
//   i_en      in   add i_a * i_b into the accumulator this cycle
//   i_a       in   DW-bit signed multiplicand (matrix element)
//   i_b       in   DW-bit signed multiplier (vector element)
//   o_result  out  accumulator reduced to DW bits
// -----------------------------------------------------------------------------
module mxv_mac #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_result
);

  logic signed [2*DW-1:0] w_prod;
  logic        [AW-1:0]   w_prod_ext;
  logic        [AW-1:0]   r_acc;

  // Full-precision signed product; AW is always wider than 2*DW because
  // N >= 2 contributes at least one growth bit.
  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(AW - 2 * DW){w_prod[2*DW-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

`ifdef MXV_SATURATE_EN
  logic signed [AW-1:0] w_acc_s;
  logic signed [AW-1:0] w_max;
  logic signed [AW-1:0] w_min;

  assign w_acc_s = r_acc;
  assign w_max   = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  assign w_min   = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  always_comb begin
    o_result = r_acc[DW-1:0];
    if (w_acc_s > w_max) begin
      o_result = {1'b0, {(DW - 1){1'b1}}};
    end else if (w_acc_s < w_min) begin
      o_result = {1'b1, {(DW - 1){1'b0}}};
    end
  end
`else
  assign o_result = r_acc[DW-1:0];
`endif

endmodule

// File: rtl/mxv_dot_accum.sv
// -----------------------------------------------------------------------------
// mxv_dot_accum
// Row-wise dot-product engine. After start, accepts N (mat, vec) pairs per
// row, multiply-accumulates them, presents one DW-bit result per row, and
// repeats for N rows. done pulses one cycle after the last row is taken.
//
// Configuration macro: MXV_SATURATE_EN (saturating result reduction, see
// mxv_mac); the default build wraps the result to the low DW bits.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high, result and row_idx hold until that transfer.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-low
//   clr          in   synchronous abort to IDLE; beats start and handshakes
//   start        in   begin a job of N rows (sampled only in IDLE)
//   in_valid     in   mat_data/vec_data pair valid
//   in_ready     out  engine accepts a pair this cycle (ACCUM only)
//   mat_data     in   DW-bit signed matrix element
//   vec_data     in   DW-bit signed vector element
//   out_valid    out  result valid (OUTPUT only)
//   out_ready    in   downstream accepts result
//   result       out  row dot product reduced to DW bits
//   row_idx      out  row being accumulated or presented
//   busy         out  high whenever the engine is not IDLE
//   done         out  one-cycle pulse after the last row's result transfers
//   o_dbg_state  out  current FSM state (mxv_dot_state_t encoding)
//
// AW must not be overridden below 2*DW + $clog2(N).
// -----------------------------------------------------------------------------
module mxv_dot_accum #(
  parameter int DW = mxv_pkg::DW,
  parameter int N  = mxv_pkg::N,
  parameter int AW = 2 * DW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        mat_data,
  input  logic [DW-1:0]        vec_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        result,
  output logic [$clog2(N)-1:0] row_idx,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);

  import mxv_pkg::*;

  localparam int             RW   = $clog2(N);
  localparam logic [RW-1:0]  LAST = RW'(N - 1);

  mxv_dot_state_t r_state;
  logic [RW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic           r_done;

  logic           w_accept;
  logic           w_mac_clr;

  // r_in_ready is high exactly in ACCUM, so it doubles as the state qualifier.
  assign w_accept = in_valid && r_in_ready;

  // The accumulator starts from zero for every row: on a fresh job, after
  // each result transfer, and on abort.
  assign w_mac_clr = clr
                   || ((r_state == IDLE) && start)
                   || ((r_state == OUTPUT) && out_ready);

  mxv_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_mac_clr),
    .i_en     (w_accept),
    .i_a      (mat_data),
    .i_b      (vec_data),
    .o_result (result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_state     <= IDLE;
        r_col       <= '0;
        r_row       <= '0;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= ACCUM;
              r_col      <= '0;
              r_row      <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          ACCUM: begin
            if (w_accept) begin
              if (r_col == LAST) begin
                // The last product lands in the accumulator on this same edge.
                r_col       <= '0;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= OUTPUT;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
          OUTPUT: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              if (r_row == LAST) begin
                r_state <= IDLE;
                r_row   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_row      <= r_row + 1'b1;
                r_in_ready <= 1'b1;
                r_state    <= ACCUM;
              end
            end
          end
          default: begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign row_idx     = r_row;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mxv_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_mxv_dot_accum
// Self-checking bench for mxv_dot_accum (DW=8, N=4). Expected row results come
// from a plain-arithmetic dot product reduced by ref_reduce, which follows the
// MXV_SATURATE_EN setting of the build. Inputs change on the falling edge and
// outputs are sampled there too, so every value seen was set by the prior
// rising edge.
// -----------------------------------------------------------------------------
module tb_mxv_dot_accum;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mat_data;
  logic [DW-1:0] vec_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [1:0]    row_idx;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  mxv_dot_accum #(.DW(DW), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mat_data    (mat_data),
    .vec_data    (vec_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .row_idx     (row_idx),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_reduce(input longint s);
`ifdef MXV_SATURATE_EN
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
`endif
    return s[DW-1:0];
  endfunction

  function automatic longint ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Present a pair until it is taken; returns on the falling edge after the
  // accepting rising edge with in_valid dropped (the caller may re-raise it
  // at once for back-to-back transfers).
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
    int waited;
    waited   = 0;
    ok       = 1'b1;
    mat_data = a;
    vec_data = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mat_data = '0; vec_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (result !== 8'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
    n_checks++; if (row_idx !== 2'd0) begin n_fail++; $display("FAIL reset_row_idx: got %0d expected 0", row_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (dbg_state !== 2'(mxv_pkg::IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b in_ready %b expected 0 0", busy, in_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] m[N];
    bit ok, all_ok;
    m = '{8'd1, 8'd2, 8'd3, 8'd4};
    all_ok = 1'b1;
    out_ready = 1'b1;
    start_job();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_latency: in_ready %b expected 1", in_ready); end
    for (int r = 0; r < N; r++) begin
      start = (r == 0);  // start while busy must be ignored
      for (int c = 0; c < N; c++) begin
        send_pair(m[c], 8'd1, ok);
        all_ok &= ok;
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_latency row %0d: out_valid %b expected 1", r, out_valid); end
      n_checks++; if (result !== 8'd10) begin n_fail++; $display("FAIL basic_result row %0d: got %0d expected 10", r, result); end
      n_checks++; if (row_idx !== 2'(r)) begin n_fail++; $display("FAIL basic_row_idx: got %0d expected %0d", row_idx, r); end
      @(negedge clk);
      if (r < N - 1) begin
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_next_row %0d: in_ready %b out_valid %b expected 1 0", r, in_ready, out_valid); end
      end else begin
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: done %b busy %b expected 1 0", done, busy); end
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done %b expected 0", done); end
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL basic_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_pos, exp_neg;
    bit ok, all_ok;
`ifdef MXV_SATURATE_EN
    exp_pos = 8'd127;
    exp_neg = 8'h80;
`else
    exp_pos = 8'd4;
    exp_neg = 8'd0;
`endif
    all_ok = 1'b1;
    out_ready = 1'b1;
    start_job();
    for (int c = 0; c < N; c++) begin send_pair(8'd127, 8'd127, ok); all_ok &= ok; end
    n_checks++; if (result !== exp_pos) begin n_fail++; $display("FAIL overflow_pos: got %0d expected %0d", result, exp_pos); end
    @(negedge clk);
    for (int c = 0; c < N; c++) begin send_pair(8'h80, 8'd127, ok); all_ok &= ok; end
    n_checks++; if (result !== exp_neg || row_idx !== 2'd1) begin n_fail++; $display("FAIL overflow_neg: got %0d row %0d expected %0d row 1", result, row_idx, exp_neg); end
    @(negedge clk);
    do_clr();
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL overflow_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a0[N], b0[N], a1[N], b1[N];
    logic [DW-1:0] e0, e1;
    longint s0, s1;
    bit ok, all_ok;
    s0 = 0; s1 = 0; all_ok = 1'b1;
    for (int c = 0; c < N; c++) begin
      a0[c] = 8'($urandom_range(0, 255)); b0[c] = 8'($urandom_range(0, 255));
      a1[c] = 8'($urandom_range(0, 255)); b1[c] = 8'($urandom_range(0, 255));
      s0 += ref_mul(a0[c], b0[c]);
      s1 += ref_mul(a1[c], b1[c]);
    end
    e0 = ref_reduce(s0); e1 = ref_reduce(s1);
    out_ready = 1'b0;
    start_job();
    for (int c = 0; c < N; c++) begin send_pair(a0[c], b0[c], ok); all_ok &= ok; end
    mat_data = a1[0]; vec_data = b1[0]; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", k, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || result !== e0 || row_idx !== 2'd0) begin
        n_fail++; $display("FAIL stall_hold cyc %0d: valid %b result %0d row %0d expected 1 %0d 0", k, out_valid, result, row_idx, e0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || row_idx !== 2'd1) begin n_fail++; $display("FAIL stall_release: in_ready %b row %0d expected 1 1", in_ready, row_idx); end
    for (int c = 0; c < N; c++) begin send_pair(a1[c], b1[c], ok); all_ok &= ok; end
    n_checks++; if (out_valid !== 1'b1 || result !== e1) begin n_fail++; $display("FAIL stall_next_row: valid %b result %0d expected 1 %0d", out_valid, result, e1); end
    @(negedge clk);
    do_clr();
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL stall_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] m[N];
    bit ok, all_ok;
    m = '{8'd2, 8'hFD, 8'd5, 8'd1};
    all_ok = 1'b1;
    out_ready = 1'b1;
    start_job();
    for (int c = 0; c < N; c++) begin
      send_pair(m[c], 8'd4, ok);
      all_ok &= ok;
      if (c < N - 1) @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1 || result !== 8'd20) begin n_fail++; $display("FAIL gaps_result: valid %b result %0d expected 1 20", out_valid, result); end
    @(negedge clk);
    do_clr();
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL gaps_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_clr();
    logic [DW-1:0] a[N], b[N];
    longint s;
    int done_seen;
    bit ok, all_ok;
    s = 0; done_seen = 0; all_ok = 1'b1;
    for (int c = 0; c < N; c++) begin
      a[c] = 8'($urandom_range(0, 255)); b[c] = 8'($urandom_range(0, 255));
      s += ref_mul(a[c], b[c]);
    end
    out_ready = 1'b1;
    start_job();
    for (int c = 0; c < N; c++) begin send_pair(a[c], b[c], ok); all_ok &= ok; end
    n_checks++; if (result !== ref_reduce(s)) begin n_fail++; $display("FAIL clr_row0: got %0d expected %0d", result, ref_reduce(s)); end
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin send_pair(8'd7, 8'd9, ok); all_ok &= ok; end
    clr = 1'b1; start = 1'b1; in_valid = 1'b1; mat_data = 8'd50; vec_data = 8'd50;
    @(negedge clk);
    clr = 1'b0; start = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle: busy %b in_ready %b out_valid %b expected 0 0 0", busy, in_ready, out_valid);
    end
    n_checks++; if (row_idx !== 2'd0 || result !== 8'd0) begin n_fail++; $display("FAIL clr_cleared: row %0d result %0d expected 0 0", row_idx, result); end
    for (int k = 0; k < 3; k++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL clr_no_done: got %0d pulses expected 0", done_seen); end
    start_job();
    for (int c = 0; c < N; c++) begin send_pair(8'd1, 8'd3, ok); all_ok &= ok; end
    n_checks++; if (result !== 8'd12 || row_idx !== 2'd0) begin n_fail++; $display("FAIL clr_restart: result %0d row %0d expected 12 0", result, row_idx); end
    @(negedge clk);
    do_clr();
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL clr_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a[N], b[N];
    longint s;
    bit ok, all_ok;
    s = 0; all_ok = 1'b1;
    for (int c = 0; c < N; c++) begin
      a[c] = 8'($urandom_range(0, 255)); b[c] = 8'($urandom_range(0, 255));
      s += ref_mul(a[c], b[c]);
    end
    out_ready = 1'b1;
    start_job();
    for (int c = 0; c < N; c++) begin send_pair(8'd3, 8'd3, ok); all_ok &= ok; end
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < N; c++) begin send_pair(8'd5, 8'd5, ok); all_ok &= ok; end
    n_checks++; if (out_valid !== 1'b1 || row_idx !== 2'd1) begin n_fail++; $display("FAIL rstmid_pre: valid %b row %0d expected 1 1", out_valid, row_idx); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: in_ready %b out_valid %b busy %b done %b expected all 0", in_ready, out_valid, busy, done);
    end
    n_checks++; if (result !== 8'd0 || row_idx !== 2'd0) begin n_fail++; $display("FAIL rstmid_data: result %0d row %0d expected 0 0", result, row_idx); end
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || row_idx !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_restart: busy %b in_ready %b row %0d expected 1 1 0", busy, in_ready, row_idx);
    end
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin send_pair(a[c], b[c], ok); all_ok &= ok; end
    n_checks++; if (result !== ref_reduce(s) || row_idx !== 2'd0) begin n_fail++; $display("FAIL rstmid_row: result %0d row %0d expected %0d 0", result, row_idx, ref_reduce(s)); end
    @(negedge clk);
    do_clr();
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL rstmid_accept: got timeout expected all pairs accepted"); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a[N*N], b[N*N];
    for (int job = 0; job < 3; job++) begin
      int rows_got, cyc, done_cnt;
      bit all_ok;
      rows_got = 0; cyc = 0; done_cnt = 0; all_ok = 1'b1;
      exp_q.delete();
      for (int r = 0; r < N; r++) begin
        longint s;
        s = 0;
        for (int c = 0; c < N; c++) begin
          a[r*N+c] = 8'($urandom_range(0, 255));
          b[r*N+c] = 8'($urandom_range(0, 255));
          s += ref_mul(a[r*N+c], b[r*N+c]);
        end
        exp_q.push_back(ref_reduce(s));
      end
      out_ready = 1'b0;
      start_job();
      fork
        begin
          bit ok;
          for (int i = 0; i < N * N; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_pair(a[i], b[i], ok);
            all_ok &= ok;
          end
        end
        begin
          while (rows_got < N && cyc < 600) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
              logic [DW-1:0] e;
              e = exp_q.pop_front();
              n_checks++; if (result !== e || row_idx !== 2'(rows_got)) begin
                n_fail++; $display("FAIL b2b job %0d row %0d: result %0d row_idx %0d expected %0d %0d", job, rows_got, result, row_idx, e, rows_got);
              end
              rows_got++;
            end
            @(negedge clk);
            cyc++;
          end
        end
      join
      for (int k = 0; k < 3; k++) begin
        if (done) done_cnt++;
        @(negedge clk);
      end
      n_checks++; if (rows_got != N) begin n_fail++; $display("FAIL b2b_rows job %0d: got %0d rows expected %0d", job, rows_got, N); end
      n_checks++; if (done_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done job %0d: pulses %0d busy %b expected 1 0", job, done_cnt, busy); end
      n_checks++; if (!all_ok) begin n_fail++; $display("FAIL b2b_accept job %0d: got timeout expected all pairs accepted", job); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_clr();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
